onehot23_to_bcd16_encoder: RTL

- Inverse of the team's 16-to-23 code decoder: converts a 23-bit one-hot selection vector back to its 16-bit BCD code, 0x0100..0x0122.
- Encoding is sequential: a bit-serial scan FSM walks the captured vector while a 4-digit BCD counter tracks the code of the current bit position.
- Valid/ready handshakes on both sides. Non-one-hot inputs are flagged.
- Sits between the selection logic and the code bus that feeds the decoder.

---
 rtl/onehot23_to_bcd16_encoder.sv | 97 +++++++++
 1 files changed

// File: rtl/onehot23_to_bcd16_encoder.sv
// onehot23_to_bcd16_encoder: bit-serial scan of a 23-bit one-hot vector into its BCD code 0x0100..0x0122
module onehot23_to_bcd16_encoder #(
  parameter int          N_CODES   = 23,
  parameter logic [15:0] BASE_CODE = 16'h0100
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_CODES-1:0] q_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        d_out,
  output logic               err
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [N_CODES-1:0] shreg_q, shreg_d;
  logic [15:0] bcd_q, bcd_d, res_q, res_d, d_out_q, d_out_d, bcd_inc;
  logic [4:0] bit_q, bit_d;
  logic [1:0] hits_q, hits_d;
  logic err_q, err_d, out_valid_q, out_valid_d, carry, last;
  always_comb begin
    bcd_inc = bcd_q;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bcd_inc[4*i +: 4] = carry ? (bcd_q[4*i +: 4] == 4'd9 ? 4'd0 : bcd_q[4*i +: 4] + 4'd1) : bcd_q[4*i +: 4];
      carry = carry && bcd_q[4*i +: 4] == 4'd9;
    end
  end
  assign last = bit_q == 5'(N_CODES - 1);
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d = bcd_q;
    bit_d = bit_q;
    hits_d = hits_q;
    res_d = res_q;
    d_out_d = d_out_q;
    err_d = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (in_valid) begin
        shreg_d = q_in;
        bcd_d = BASE_CODE;
        bit_d = '0;
        hits_d = '0;
        state_d = SCAN;
      end
      SCAN: begin
        res_d = shreg_q[0] ? bcd_q : res_q;
        hits_d = shreg_q[0] ? (hits_q == 2'd2 ? 2'd2 : hits_q + 2'd1) : hits_q;
        shreg_d = shreg_q >> 1;
        // counter stops at the last code instead of stepping past it
        bcd_d = last ? bcd_q : bcd_inc;
        bit_d = bit_q + 5'd1;
        if (last) begin
          state_d = DONE;
          out_valid_d = 1'b1;
          d_out_d = hits_d == 2'd1 ? res_d : 16'h0000;
          err_d = hits_d != 2'd1;
        end
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcd_q <= '0;
      bit_q <= '0;
      hits_q <= '0;
      res_q <= '0;
      d_out_q <= '0;
      err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcd_q <= bcd_d;
      bit_q <= bit_d;
      hits_q <= hits_d;
      res_q <= res_d;
      d_out_q <= d_out_d;
      err_q <= err_d;
      out_valid_q <= out_valid_d;
    end
  assign in_ready = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign d_out = d_out_q;
  assign err = err_q;
endmodule
